cv32e41p_trace_buffer: RTL and testbench

//  Multi-channel retired-instruction trace capture buffer; parametrised successor to the single-hart core log/tracer.

---
 rtl/cv32e41p_trace_buffer.sv | 169 ++++++++++++++++
 tb/tb_cv32e41p_trace_buffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41p_trace_buffer.sv
// Multi-channel retired-instruction trace buffer.
// Round-robin arbitrated capture into one shared FWFT FIFO.
module cv32e41p_trace_buffer #(
    parameter int NUM_CH    = 1,
    parameter int DEPTH     = 8,
    parameter int TS_W      = 16,
    parameter int DROP_W    = 8,
    parameter int DROP_MODE = 0,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic                 filter_ill_i,
    input  logic [NUM_CH-1:0]    ch_valid_i,
    output logic [NUM_CH-1:0]    ch_ready_o,
    input  logic [NUM_CH*32-1:0] ch_pc_i,
    input  logic [NUM_CH*32-1:0] ch_instr_i,
    input  logic [NUM_CH-1:0]    ch_illegal_i,
    output logic                 rec_valid_o,
    input  logic                 rec_ready_i,
    output logic [CH_W-1:0]      rec_ch_o,
    output logic [31:0]          rec_pc_o,
    output logic [31:0]          rec_instr_o,
    output logic                 rec_illegal_o,
    output logic [TS_W-1:0]      rec_ts_o,
    output logic [CNT_W-1:0]     count_o,
    output logic [DROP_W-1:0]    drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [31:0]     pc;
        logic [31:0]     instr;
        logic            illegal;
        logic [TS_W-1:0] ts;
    } rec_t;

    rec_t              mem [DEPTH];
    rec_t              head;
    rec_t              wr_rec;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic [TS_W-1:0]   ts;
    logic [DROP_W-1:0] drop;
    logic [DROP_W-1:0] drop_next;
    logic [DROP_W+3:0] drop_sum;
    logic [3:0]        drop_inc;
    logic              any_valid;
    logic              filtered;
    logic              pop;
    logic              can_push;
    logic              push;
    logic              rr_adv;

    // Lowest offset from rr_ptr wins, so scan offsets downward.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (ch_valid_i[idx]) begin
                grant     = CH_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign filtered = any_valid & filter_ill_i & ~ch_illegal_i[grant];
    assign pop      = rec_valid_o & rec_ready_i & ~clear_i;
    assign can_push = ~clear_i & ((count < CNT_W'(DEPTH)) | pop);
    assign push     = enable_i & any_valid & ~filtered & can_push;
    assign rr_adv   = enable_i & any_valid & (filtered | can_push);

    always_comb begin
        ch_ready_o = '0;
        if (!enable_i || DROP_MODE != 0) begin
            ch_ready_o = '1;
        end else if (any_valid && (can_push || filtered)) begin
            ch_ready_o[grant] = 1'b1;
        end
    end

    // Every valid, unfiltered record that is not the pushed one is lost.
    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid_i[i] && (!filter_ill_i || ch_illegal_i[i])) begin
                drop_inc = drop_inc + 4'd1;
            end
        end
        if (push) begin
            drop_inc = drop_inc - 4'd1;
        end
        if (!enable_i || DROP_MODE == 0) begin
            drop_inc = '0;
        end
        drop_sum  = {4'b0, drop} + (DROP_W+4)'(drop_inc);
        drop_next = (drop_sum > {4'b0, {DROP_W{1'b1}}}) ? '1
                                                         : drop_sum[DROP_W-1:0];
    end

    assign wr_rec.ch      = grant;
    assign wr_rec.pc      = ch_pc_i[32*grant +: 32];
    assign wr_rec.instr   = ch_instr_i[32*grant +: 32];
    assign wr_rec.illegal = ch_illegal_i[grant];
    assign wr_rec.ts      = ts;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
            ts     <= '0;
            drop   <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (rr_adv) begin
                rr_ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
            end
            if (clear_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                drop   <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
                drop <= drop_next;
            end
        end
    end

    assign head          = mem[rd_ptr];
    assign rec_valid_o   = (count != '0);
    assign rec_ch_o      = rec_valid_o ? head.ch : '0;
    assign rec_pc_o      = rec_valid_o ? head.pc : '0;
    assign rec_instr_o   = rec_valid_o ? head.instr : '0;
    assign rec_illegal_o = rec_valid_o ? head.illegal : 1'b0;
    assign rec_ts_o      = rec_valid_o ? head.ts : '0;
    assign count_o       = count;
    assign drop_cnt_o    = drop;

endmodule

// File: tb/tb_cv32e41p_trace_buffer.sv
// Directed bench for the trace buffer: table of cycle vectors
// plus hand sequences for timestamp, drop mode and saturation.
module tb_cv32e41p_trace_buffer;

    logic        clk = 1'b0;
    logic        rst, en, clr, flt, rdy;
    logic [1:0]  v, ill;
    logic [63:0] pc, instr;
    logic [15:0] tb_ts;
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  r0_ready;
    logic        r0_rv, r0_ch, r0_ill;
    logic [31:0] r0_pc, r0_instr;
    logic [15:0] r0_ts;
    logic [2:0]  r0_cnt;
    logic [7:0]  r0_drop;

    logic [1:0]  r1_ready;
    logic        r1_rv, r1_ch, r1_ill;
    logic [31:0] r1_pc, r1_instr;
    logic [15:0] r1_ts;
    logic [1:0]  r1_cnt;
    logic [7:0]  r1_drop;

    logic [1:0]  r2_ready;
    logic        r2_rv, r2_ch, r2_ill;
    logic [31:0] r2_pc, r2_instr;
    logic [15:0] r2_ts;
    logic [1:0]  r2_cnt;
    logic [1:0]  r2_drop;

    logic [0:0]  r3_ready;
    logic        r3_rv, r3_ch, r3_ill;
    logic [31:0] r3_pc, r3_instr;
    logic [15:0] r3_ts;
    logic [3:0]  r3_cnt;
    logic [7:0]  r3_drop;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 16'd1;
    end

    cv32e41p_trace_buffer #(.NUM_CH(2), .DEPTH(4), .DROP_MODE(0)) u0 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .filter_ill_i(flt), .ch_valid_i(v), .ch_ready_o(r0_ready),
        .ch_pc_i(pc), .ch_instr_i(instr), .ch_illegal_i(ill),
        .rec_valid_o(r0_rv), .rec_ready_i(rdy), .rec_ch_o(r0_ch),
        .rec_pc_o(r0_pc), .rec_instr_o(r0_instr), .rec_illegal_o(r0_ill),
        .rec_ts_o(r0_ts), .count_o(r0_cnt), .drop_cnt_o(r0_drop));

    cv32e41p_trace_buffer #(.NUM_CH(2), .DEPTH(2), .DROP_MODE(1)) u1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .filter_ill_i(flt), .ch_valid_i(v), .ch_ready_o(r1_ready),
        .ch_pc_i(pc), .ch_instr_i(instr), .ch_illegal_i(ill),
        .rec_valid_o(r1_rv), .rec_ready_i(rdy), .rec_ch_o(r1_ch),
        .rec_pc_o(r1_pc), .rec_instr_o(r1_instr), .rec_illegal_o(r1_ill),
        .rec_ts_o(r1_ts), .count_o(r1_cnt), .drop_cnt_o(r1_drop));

    cv32e41p_trace_buffer #(.NUM_CH(2), .DEPTH(2), .DROP_W(2),
                            .DROP_MODE(1)) u2 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .filter_ill_i(flt), .ch_valid_i(v), .ch_ready_o(r2_ready),
        .ch_pc_i(pc), .ch_instr_i(instr), .ch_illegal_i(ill),
        .rec_valid_o(r2_rv), .rec_ready_i(rdy), .rec_ch_o(r2_ch),
        .rec_pc_o(r2_pc), .rec_instr_o(r2_instr), .rec_illegal_o(r2_ill),
        .rec_ts_o(r2_ts), .count_o(r2_cnt), .drop_cnt_o(r2_drop));

    cv32e41p_trace_buffer #(.NUM_CH(1), .DEPTH(8)) u3 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .filter_ill_i(flt), .ch_valid_i(v[0:0]), .ch_ready_o(r3_ready),
        .ch_pc_i(pc[31:0]), .ch_instr_i(instr[31:0]),
        .ch_illegal_i(ill[0:0]),
        .rec_valid_o(r3_rv), .rec_ready_i(rdy), .rec_ch_o(r3_ch),
        .rec_pc_o(r3_pc), .rec_instr_o(r3_instr), .rec_illegal_o(r3_ill),
        .rec_ts_o(r3_ts), .count_o(r3_cnt), .drop_cnt_o(r3_drop));

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  ill;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        flt, rdy, clr, en;
        logic [1:0]  e_rdy;
        int          e_cnt;
        logic        e_ch;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] vv, logic [1:0] ii,
                                logic [31:0] p0, logic [31:0] p1,
                                logic f, logic r, logic c, logic e,
                                logic [1:0] er, int ec, logic ech,
                                logic [31:0] epc);
        vec_t t;
        t.v = vv; t.ill = ii; t.pc0 = p0; t.pc1 = p1;
        t.flt = f; t.rdy = r; t.clr = c; t.en = e;
        t.e_rdy = er; t.e_cnt = ec; t.e_ch = ech; t.e_pc = epc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        v = 2'b00; ill = 2'b00; flt = 1'b0; clr = 1'b0; en = 1'b1;
        rdy = 1'b0; pc = '0; instr = '0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        do_reset();

        // reset state
        chk("rst_rv", r0_rv, 0);
        chk("rst_cnt", r0_cnt, 0);
        chk("rst_drop", r1_drop, 0);
        chk("rst_pc", r0_pc, 0);
        chk("rst_ts", r0_ts, 0);

        // single channel, record at ts=5
        repeat (5) tick();
        v = 2'b01; pc[31:0] = 32'h80; instr[31:0] = 32'h13; rdy = 1'b1;
        tick();
        v = 2'b00;
        chk("t1_rv", r3_rv, 1);
        chk("t1_pc", r3_pc, 32'h80);
        chk("t1_instr", r3_instr, 32'h13);
        chk("t1_ts", r3_ts, 5);
        chk("t1_cnt", r3_cnt, 1);

        // drop mode: both channels valid for 3 cycles, sink stalled
        do_reset();
        v = 2'b11; pc = {32'h2000, 32'h1000}; rdy = 1'b0;
        #1;
        chk("dm_ready0", r1_ready, 2'b11);
        tick();
        chk("dm_drop1", r2_drop, 1);
        tick();
        chk("dm_drop2", r2_drop, 2);
        chk("dm_ready1", r1_ready, 2'b11);
        tick();
        chk("dm_cnt", r1_cnt, 2);
        chk("dm_drop", r1_drop, 4);
        chk("dm_sat", r2_drop, 3);
        chk("dm_head_ch", r1_ch, 0);
        chk("dm_head_pc", r1_pc, 32'h1000);
        v = 2'b00; rdy = 1'b1;
        tick();
        chk("dm_pop_cnt", r1_cnt, 1);
        chk("dm_pop_ch", r1_ch, 1);
        chk("dm_pop_pc", r1_pc, 32'h2000);
        v = 2'b11; rdy = 1'b0; clr = 1'b1;
        tick();
        chk("dm_clr_drop", r1_drop, 0);
        chk("dm_clr_cnt", r1_cnt, 0);
        clr = 1'b0; en = 1'b0;
        tick();
        chk("dm_dis_drop", r1_drop, 0);
        chk("dm_dis_cnt", r1_cnt, 0);
        en = 1'b1;
        tick();
        chk("dm_pre_rst", r1_cnt, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_cnt", r1_cnt, 0);
        chk("mid_rst_drop", r1_drop, 0);

        // backpressure table on u0 (DEPTH=4)
        vecs.push_back(mk(2'b11, 0, 32'h100, 32'h200, 0,1,0,1, 2'b01, 1, 0, 32'h100));
        vecs.push_back(mk(2'b11, 0, 32'h104, 32'h204, 0,1,0,1, 2'b10, 1, 1, 32'h204));
        vecs.push_back(mk(2'b11, 0, 32'h108, 32'h208, 0,1,0,1, 2'b01, 1, 0, 32'h108));
        vecs.push_back(mk(2'b11, 0, 32'h10C, 32'h20C, 0,1,0,1, 2'b10, 1, 1, 32'h20C));
        vecs.push_back(mk(2'b00, 0, 0, 0,             0,1,0,1, 2'b00, 0, 0, 0));
        vecs.push_back(mk(2'b11, 3, 32'h110, 32'h210, 0,0,0,0, 2'b11, 0, 0, 0));
        vecs.push_back(mk(2'b01, 0, 32'h10, 0,        0,0,0,1, 2'b01, 1, 0, 32'h10));
        vecs.push_back(mk(2'b01, 0, 32'h14, 0,        0,0,0,1, 2'b01, 2, 0, 32'h10));
        vecs.push_back(mk(2'b01, 0, 32'h18, 0,        0,0,0,1, 2'b01, 3, 0, 32'h10));
        vecs.push_back(mk(2'b01, 0, 32'h1C, 0,        0,0,0,1, 2'b01, 4, 0, 32'h10));
        vecs.push_back(mk(2'b11, 0, 32'h20, 32'h300,  0,0,0,1, 2'b00, 4, 0, 32'h10));
        vecs.push_back(mk(2'b01, 0, 32'h20, 0,        0,1,0,1, 2'b01, 4, 0, 32'h14));
        vecs.push_back(mk(2'b00, 0, 0, 0,             0,1,0,1, 2'b00, 3, 0, 32'h18));
        vecs.push_back(mk(2'b00, 0, 0, 0,             0,1,0,1, 2'b00, 2, 0, 32'h1C));
        vecs.push_back(mk(2'b00, 0, 0, 0,             0,1,0,1, 2'b00, 1, 0, 32'h20));
        vecs.push_back(mk(2'b00, 0, 0, 0,             0,1,0,1, 2'b00, 0, 0, 0));
        vecs.push_back(mk(2'b01, 0, 32'h30, 0,        1,0,0,1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(2'b01, 1, 32'h34, 0,        1,0,0,1, 2'b01, 1, 0, 32'h34));
        vecs.push_back(mk(2'b01, 0, 32'h38, 0,        1,0,0,1, 2'b01, 1, 0, 32'h34));
        vecs.push_back(mk(2'b11, 2, 32'h3C, 32'h23C,  1,0,0,1, 2'b10, 2, 0, 32'h34));
        vecs.push_back(mk(2'b11, 2, 32'h40, 32'h240,  1,0,0,1, 2'b01, 2, 0, 32'h34));
        vecs.push_back(mk(2'b00, 0, 0, 0,             0,1,0,1, 2'b00, 1, 1, 32'h23C));
        vecs.push_back(mk(2'b00, 0, 0, 0,             0,1,0,1, 2'b00, 0, 0, 0));
        vecs.push_back(mk(2'b01, 0, 32'h50, 0,        0,0,0,1, 2'b01, 1, 0, 32'h50));
        vecs.push_back(mk(2'b01, 0, 32'h54, 0,        0,0,0,1, 2'b01, 2, 0, 32'h50));
        vecs.push_back(mk(2'b01, 0, 32'h58, 0,        0,0,0,1, 2'b01, 3, 0, 32'h50));
        vecs.push_back(mk(2'b01, 0, 32'h5C, 0,        0,1,1,1, 2'b00, 0, 0, 0));
        vecs.push_back(mk(2'b01, 0, 32'h60, 0,        0,0,0,1, 2'b01, 1, 0, 32'h60));

        do_reset();
        foreach (vecs[i]) begin
            v = vecs[i].v; ill = vecs[i].ill;
            pc = {vecs[i].pc1, vecs[i].pc0};
            flt = vecs[i].flt; rdy = vecs[i].rdy;
            clr = vecs[i].clr; en = vecs[i].en;
            #1;
            chk($sformatf("v%0d_ready", i), r0_ready, vecs[i].e_rdy);
            tick();
            chk($sformatf("v%0d_cnt", i), r0_cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d_rv", i), r0_rv, vecs[i].e_cnt != 0);
            chk($sformatf("v%0d_ch", i), r0_ch, vecs[i].e_ch);
            chk($sformatf("v%0d_pc", i), r0_pc, vecs[i].e_pc);
        end
        chk("clr_ts", r0_ts, tb_ts - 16'd1);
        chk("bp_drop", r0_drop, 0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
